// File: rtl/sdrc_app_arb.sv
// Round-robin arbiter sharing the sdrc_core application port between NREQ requesters.
// Per-direction owner FIFOs route write pulls and read returns back to the burst owner.
module sdrc_app_arb #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned AW     = 30,
  parameter int unsigned DW     = 32,
  parameter int unsigned ODEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      m_req,
  input  logic [NREQ*AW-1:0]   m_req_addr,
  input  logic [NREQ*9-1:0]    m_req_len,
  input  logic [NREQ-1:0]      m_req_wr_n,
  output logic [NREQ-1:0]      m_req_ack,
  input  logic [NREQ*DW-1:0]   m_wr_data,
  input  logic [NREQ*DW/8-1:0] m_wr_en_n,
  output logic [NREQ-1:0]      m_wr_next,
  output logic [NREQ-1:0]      m_rd_valid,
  output logic [DW-1:0]        m_rd_data,
  output logic                 app_req,
  output logic [AW-1:0]        app_req_addr,
  output logic [8:0]           app_req_len,
  output logic                 app_req_wr_n,
  input  logic                 app_req_ack,
  output logic [DW-1:0]        app_wr_data,
  output logic [DW/8-1:0]      app_wr_en_n,
  input  logic                 app_wr_next_req,
  input  logic                 app_rd_valid,
  input  logic [DW-1:0]        app_rd_data,
  output logic                 arb_err
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned PW = $clog2(ODEPTH);
  localparam int unsigned BW = DW / 8;

  typedef enum logic [1:0] {StIdle, StReq, StZack, StGap} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   grant_q, rr_ptr_q;
  logic [AW-1:0]   addr_q;
  logic [8:0]      len_q;
  logic            wr_n_q;
  logic            arb_err_q;

  logic [NREQ-1:0] elig;
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [8:0]      win_len;

  // Index 0 = write owner FIFO, index 1 = read owner FIFO.
  logic [IW-1:0]   own_mem [2][ODEPTH];
  logic [8:0]      len_mem [2][ODEPTH];
  logic [PW-1:0]   rptr_q  [2];
  logic [PW-1:0]   wptr_q  [2];
  logic [PW:0]     cnt_q   [2];
  logic [8:0]      done_q  [2];
  logic [1:0]      full, push, push_ok, strobe, head_vld, pop;
  logic [IW-1:0]   head_own [2];
  logic [8:0]      head_len [2];
  logic            err_set;

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] g);
    return (32'(g) == NREQ - 1) ? '0 : g + 1'b1;
  endfunction

  // Round-robin pick starting at rr_ptr_q; a full owner FIFO makes its direction ineligible.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      elig[i] = m_req[i] && !full[m_req_wr_n[i]];
    end
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(rr_ptr_q) + k) % NREQ;
      if (!win_found && elig[IW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
    win_len = m_req_len[win_idx*9 +: 9];
  end

  always_comb begin
    strobe  = {app_rd_valid, app_wr_next_req};
    err_set = 1'b0;
    for (int d = 0; d < 2; d++) begin
      full[d]     = cnt_q[d] == (PW+1)'(ODEPTH);
      push[d]     = (state_q == StReq) && app_req_ack && (int'(wr_n_q) == d);
      push_ok[d]  = push[d] && !full[d];
      // Empty FIFO: the entry being pushed this cycle already owns incoming strobes.
      head_vld[d] = (cnt_q[d] != '0) || push[d];
      head_own[d] = (cnt_q[d] != '0) ? own_mem[d][rptr_q[d]] : grant_q;
      head_len[d] = (cnt_q[d] != '0) ? len_mem[d][rptr_q[d]] : len_q;
      pop[d]      = strobe[d] && head_vld[d] && (done_q[d] + 9'd1 == head_len[d]);
      if ((push[d] && full[d]) || (strobe[d] && !head_vld[d])) begin
        err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (push_ok[d]) begin
        own_mem[d][wptr_q[d]] <= grant_q;
        len_mem[d][wptr_q[d]] <= len_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int d = 0; d < 2; d++) begin
        rptr_q[d] <= '0;
        wptr_q[d] <= '0;
        cnt_q[d]  <= '0;
        done_q[d] <= '0;
      end
      arb_err_q <= 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (push_ok[d]) wptr_q[d] <= wptr_q[d] + 1'b1;
        if (strobe[d] && head_vld[d]) begin
          if (pop[d]) begin
            done_q[d] <= '0;
            rptr_q[d] <= rptr_q[d] + 1'b1;
          end else begin
            done_q[d] <= done_q[d] + 9'd1;
          end
        end
        cnt_q[d] <= cnt_q[d] + (PW+1)'(push_ok[d]) - (PW+1)'(pop[d]);
      end
      if (err_set) arb_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      wr_n_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && win_found) begin
        grant_q <= win_idx;
        if (win_len == 9'd0) begin
          rr_ptr_q <= rr_next(win_idx);
        end else begin
          addr_q <= m_req_addr[win_idx*AW +: AW];
          len_q  <= win_len;
          wr_n_q <= m_req_wr_n[win_idx];
        end
      end
      if (state_q == StReq && app_req_ack) rr_ptr_q <= rr_next(grant_q);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (win_found) state_d = (win_len == 9'd0) ? StZack : StReq;
      StReq:  if (app_req_ack) state_d = StGap;
      StZack: state_d = StGap;
      StGap:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m_req_ack   = '0;
    m_wr_next   = '0;
    m_rd_valid  = '0;
    app_wr_data = '0;
    app_wr_en_n = '1;
    if ((state_q == StReq && app_req_ack) || state_q == StZack) m_req_ack[grant_q] = 1'b1;
    if (head_vld[0]) begin
      m_wr_next[head_own[0]] = app_wr_next_req;
      app_wr_data            = m_wr_data[head_own[0]*DW +: DW];
      app_wr_en_n            = m_wr_en_n[head_own[0]*BW +: BW];
    end
    if (head_vld[1]) m_rd_valid[head_own[1]] = app_rd_valid;
  end

  assign app_req      = (state_q == StReq);
  assign app_req_addr = addr_q;
  assign app_req_len  = len_q;
  assign app_req_wr_n = wr_n_q;
  assign m_rd_data    = app_rd_data;
  assign arb_err      = arb_err_q;

endmodule
